alu_shft_seq: RTL and testbench

- Multi-bit shift sequencer that sits directly upstream of the ALU shifter and closes the loop around it.
- Latches an operand, an ALU shift op and a count, then drives the shifter one bit per clock.
- Each cycle it feeds back the shifter result and carry, until the count is exhausted.
- Provides N-bit shifts and rotates (RL/RLC/RR/RRC/SLA/SLL/SRA/SRL and the A variants) for extended opcodes, without a barrel shifter.

---
 rtl/alu_shft_seq.sv | 96 +++++++++
 tb/tb_alu_shft_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_shft_seq.sv
// alu_shft_seq: N-bit shift/rotate sequencer that drives the combinational ALU shifter one bit per clock.
// Defining ALU_SHFT_SEQ_FLAGS_EN builds the registered {S,Z,P,C} flag_out; otherwise flag_out is tied low.
`ifndef AOP_IDX
`define AOP_IDX 4
`endif
module alu_shft_seq #(
    parameter int CNT_W = 3
) (
    input  logic              clkc,
    input  logic              resetb,
    input  logic              start,
    input  logic              abort,
    input  logic [`AOP_IDX:0] op_in,
    input  logic [7:0]        data_in,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              carry_in,
    output logic [7:0]        alub_out,
    output logic [`AOP_IDX:0] aluop_out,
    output logic              carry_bit_out,
    input  logic [7:0]        shft_out_in,
    input  logic              shft_c_in,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result,
    output logic              carry_out,
    output logic [3:0]        flag_out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [CNT_W:0] CNT_ONE = 1;
    state_t            r_state, w_next;
    logic [7:0]        r_data, r_result;
    logic [`AOP_IDX:0] r_op;
    logic              r_carry, r_carry_out;
    logic [CNT_W:0]    r_cnt;
    logic              w_load, w_fin;
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = start & ~abort;
                w_next = w_load ? SHIFT : IDLE;
            end
            SHIFT:   w_next = abort ? IDLE : (r_cnt == CNT_ONE ? DONE : SHIFT);
            default: w_next = IDLE;
        endcase
    end
    // DONE exposes the finished data register directly so result is valid in the done cycle,
    // and it is only captured into the held copy when that cycle is not aborted.
    assign w_fin = (r_state == DONE) & ~abort;
    always_ff @(posedge clkc or negedge resetb) begin
        if (!resetb) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_op        <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_data  <= data_in;
                r_op    <= op_in;
                r_carry <= carry_in;
                r_cnt   <= {cnt_in == '0, cnt_in};
            end else if (r_state == SHIFT) begin
                r_data  <= shft_out_in;
                r_carry <= shft_c_in;
                r_cnt   <= r_cnt - CNT_ONE;
            end
            if (w_fin) begin
                r_result    <= r_data;
                r_carry_out <= r_carry;
            end
        end
    end
    assign alub_out      = r_data;
    assign aluop_out     = r_op;
    assign carry_bit_out = r_carry;
    assign busy          = r_state != IDLE;
    assign done          = w_fin;
    assign result        = w_fin ? r_data : r_result;
    assign carry_out     = w_fin ? r_carry : r_carry_out;
`ifdef ALU_SHFT_SEQ_FLAGS_EN
    logic [3:0] r_flags, w_flags;
    assign w_flags = {r_data[7], r_data == 8'h00, ~^r_data, r_carry};
    always_ff @(posedge clkc or negedge resetb) begin
        if (!resetb) r_flags <= 4'b0000;
        else if (w_fin) r_flags <= w_flags;
    end
    assign flag_out = w_fin ? w_flags : r_flags;
`else
    assign flag_out = 4'b0000;
`endif
endmodule

// File: tb/tb_alu_shft_seq.sv
// tb_alu_shft_seq: closes the loop with a one-bit shifter model and checks N-bit results
// against closed-form shift/rotate arithmetic.
`ifndef AOP_IDX
`define AOP_IDX 4
`endif
module tb_alu_shft_seq;
    localparam int CNT_W = 3;
    localparam int OPW   = `AOP_IDX + 1;
    localparam logic [OPW-1:0] RLC = 1, RRC = 2, RL = 3, RR = 4, SLA = 5, SRA = 6, SLL = 7, SRL = 8;
    localparam logic [OPW-1:0] RLCA = 9, RRCA = 10, RLA = 11, RRA = 12, ADD = 20;

    logic             clkc, resetb, start, abort, carry_in;
    logic [OPW-1:0]   op_in, aluop_out;
    logic [7:0]       data_in, alub_out, shft_out_in, result;
    logic [CNT_W-1:0] cnt_in;
    logic             carry_bit_out, shft_c_in, busy, done, carry_out;
    logic [3:0]       flag_out;
    logic [8:0]       prev;
    logic [OPW-1:0]   ops [13] = '{RLC, RRC, RL, RR, SLA, SRA, SLL, SRL, RLCA, RRCA, RLA, RRA, ADD};
    int checks = 0;
    int errors = 0;

    alu_shft_seq #(.CNT_W(CNT_W)) dut (
        .clkc(clkc), .resetb(resetb), .start(start), .abort(abort), .op_in(op_in),
        .data_in(data_in), .cnt_in(cnt_in), .carry_in(carry_in), .alub_out(alub_out),
        .aluop_out(aluop_out), .carry_bit_out(carry_bit_out), .shft_out_in(shft_out_in),
        .shft_c_in(shft_c_in), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .flag_out(flag_out)
    );

    initial clkc = 1'b0;
    always #5 clkc = ~clkc;

    // single-bit shifter sitting in the loop
    always_comb begin
        {shft_c_in, shft_out_in} = 9'h000;
        case (aluop_out)
            RLC, RLCA: {shft_c_in, shft_out_in} = {alub_out[7], alub_out[6:0], alub_out[7]};
            RRC, RRCA: {shft_c_in, shft_out_in} = {alub_out[0], alub_out[0], alub_out[7:1]};
            RL, RLA:   {shft_c_in, shft_out_in} = {alub_out[7], alub_out[6:0], carry_bit_out};
            RR, RRA:   {shft_c_in, shft_out_in} = {alub_out[0], carry_bit_out, alub_out[7:1]};
            SLA:       {shft_c_in, shft_out_in} = {alub_out[7], alub_out[6:0], 1'b0};
            SLL:       {shft_c_in, shft_out_in} = {alub_out[7], alub_out[6:0], 1'b1};
            SRA:       {shft_c_in, shft_out_in} = {alub_out[0], alub_out[7], alub_out[7:1]};
            SRL:       {shft_c_in, shft_out_in} = {alub_out[0], 1'b0, alub_out[7:1]};
            default: ;
        endcase
    end

    // closed-form n-bit result as {carry, data}
    function automatic logic [8:0] ref_shift(input logic [OPW-1:0] op, input logic [7:0] d,
                                             input logic c, input int n);
        logic [15:0] x;
        logic [17:0] v;
        case (op)
            RLC, RLCA: begin x = {d, d} << (n % 8); return {x[8], x[15:8]}; end
            RRC, RRCA: begin x = {d, d} >> (n % 8); return {x[7], x[7:0]}; end
            RL, RLA:   begin v = {9'b0, c, d} << n; return v[8:0] | v[17:9]; end
            RR, RRA:   begin v = {c, d, 9'b0} >> n; return v[17:9] | v[8:0]; end
            SLA:       begin x = {8'h00, d} << n; return {x[8], x[7:0]}; end
            SLL:       begin x = ({8'h00, d} << n) | 16'((1 << n) - 1); return {x[8], x[7:0]}; end
            SRA:       begin x = 16'($signed({d, 8'h00}) >>> n); return {x[7], x[15:8]}; end
            SRL:       begin x = {d, 8'h00} >> n; return {x[7], x[15:8]}; end
            default:   return 9'h000;
        endcase
    endfunction

    function automatic logic [3:0] exp_flags(input logic [7:0] r, input logic c);
`ifdef ALU_SHFT_SEQ_FLAGS_EN
        return {r[7], r == 8'h00, ~^r, c};
`else
        return 4'b0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // poke>0 re-requests start with other operands at that busy cycle; at_done requests start in the done cycle
    task automatic run_op(input logic [OPW-1:0] op, input logic [7:0] d, input logic [CNT_W-1:0] cn,
                          input logic c, input int poke, input bit at_done);
        int n, k;
        bit busy_ok;
        logic [8:0] e;
        n = (cn == 0) ? (1 << CNT_W) : int'(cn);
        e = ref_shift(op, d, c, n);
        @(negedge clkc);
        start = 1'b1; op_in = op; data_in = d; cnt_in = cn; carry_in = c;
        @(posedge clkc);
        #1 start = 1'b0; op_in = ADD; data_in = 8'($urandom); cnt_in = CNT_W'($urandom); carry_in = 1'($urandom);
        k = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clkc);
            k++;
            if (!busy) busy_ok = 1'b0;
            start = (k == poke);
            if (k == poke) data_in = ~d;
        end while (!done && k < 20);
        chk("latency", k, n + 1);
        chk("busy_span", busy_ok, 1'b1);
        chk("result", result, e[7:0]);
        chk("carry_out", carry_out, e[8]);
        chk("flags", flag_out, exp_flags(e[7:0], e[8]));
        start = at_done;
        @(negedge clkc);
        start = 1'b0;
        chk("busy_drop", busy, 1'b0);
        chk("done_pulse", done, 1'b0);
        chk("result_hold", {carry_out, result}, e);
    endtask

    initial begin
        resetb = 1'b0; start = 1'b0; abort = 1'b0; op_in = '0; data_in = 8'h00; cnt_in = '0; carry_in = 1'b0;
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_alub", alub_out, 8'h00);
        chk("rst_aluop", aluop_out, '0);
        chk("rst_cbit", carry_bit_out, 1'b0);
        chk("rst_flags", flag_out, 4'b0000);
        @(negedge clkc);
        resetb = 1'b1;
        run_op(RLC, 8'h81, 3'd1, 1'b0, 0, 1'b0);
        chk("plan_rlc", {carry_out, result}, 9'h103);
        run_op(RL, 8'h80, 3'd0, 1'b0, 0, 1'b0);
        chk("plan_rl", {carry_out, result}, 9'h040);
        run_op(SRA, 8'h80, 3'd3, 1'b0, 0, 1'b0);
        chk("plan_sra", {carry_out, result}, 9'h0F0);
        chk("plan_sra_flags", flag_out, exp_flags(8'hF0, 1'b0));
        run_op(SRL, 8'h0F, 3'd0, 1'b0, 0, 1'b0);
        chk("plan_srl", {carry_out, result}, 9'h000);
        chk("plan_srl_flags", flag_out, exp_flags(8'h00, 1'b0));
        run_op(SLA, 8'hA5, 3'd5, 1'b1, 2, 1'b0);
        run_op(RRC, 8'h3C, 3'd2, 1'b0, 0, 1'b1);
        chk("plan_rrc", {carry_out, result}, 9'h00F);
        // abort in the second shift cycle of an 8-shift op
        prev = {carry_out, result};
        @(negedge clkc);
        start = 1'b1; op_in = RL; data_in = 8'h5A; cnt_in = 3'd0; carry_in = 1'b1;
        @(posedge clkc);
        #1 start = 1'b0;
        @(negedge clkc);
        @(negedge clkc);
        abort = 1'b1;
        chk("abort_busy", busy, 1'b1);
        @(posedge clkc);
        #1 abort = 1'b0;
        @(negedge clkc);
        chk("abort_idle", busy, 1'b0);
        chk("abort_result", {carry_out, result}, prev);
        begin
            bit seen = 1'b0;
            repeat (12) begin
                @(negedge clkc);
                seen |= done;
            end
            chk("abort_no_done", seen, 1'b0);
        end
        chk("abort_hold", {carry_out, result}, prev);
        // abort during the done cycle
        @(negedge clkc);
        start = 1'b1; op_in = SRL; data_in = 8'h03; cnt_in = 3'd1; carry_in = 1'b0;
        @(posedge clkc);
        #1 start = 1'b0;
        @(posedge clkc);
        #1 abort = 1'b1;
        @(negedge clkc);
        chk("abortd_busy", busy, 1'b1);
        chk("abortd_done", done, 1'b0);
        chk("abortd_result", {carry_out, result}, prev);
        @(posedge clkc);
        #1 abort = 1'b0;
        @(negedge clkc);
        chk("abortd_idle", busy, 1'b0);
        chk("abortd_hold", {carry_out, result}, prev);
        // abort in IDLE blocks start
        @(negedge clkc);
        start = 1'b1; abort = 1'b1;
        @(posedge clkc);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clkc);
        chk("abort_idle_blocks", busy, 1'b0);
        for (int i = 0; i < 40; i++)
            run_op(ops[$urandom_range(0, 12)], 8'($urandom), CNT_W'($urandom), 1'($urandom), 0, 1'b0);
        // reset in the middle of a shift
        @(negedge clkc);
        start = 1'b1; op_in = SLL; data_in = 8'h11; cnt_in = 3'd0; carry_in = 1'b1;
        @(posedge clkc);
        #1 start = 1'b0;
        repeat (3) @(negedge clkc);
        chk("prerst_busy", busy, 1'b1);
        #1 resetb = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_result", result, 8'h00);
        chk("mrst_carry", carry_out, 1'b0);
        chk("mrst_alub", alub_out, 8'h00);
        chk("mrst_aluop", aluop_out, '0);
        chk("mrst_flags", flag_out, 4'b0000);
        @(negedge clkc);
        resetb = 1'b1;
        run_op(SRA, 8'h7E, 3'd2, 1'b0, 0, 1'b0);
        chk("post_rst", {carry_out, result}, 9'h11F);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
